// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_seq instruction sequencer.
//   state_t          : sequencer states, also exported on the debug port
//   NOP_INSTR        : instruction register value after reset (addi x0,x0,0)
//   DEFAULT_RESET_PC : default fetch address after reset
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_IWAIT,
    S_EXEC,
    S_MEM,
    S_DWAIT,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/cpu_seq_perf_cnt.sv
// perf_cnt: 64-bit cycle and retired-instruction counters.
// Only exists when PERF_CNT_EN is defined.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_run           : count this cycle (core not halted)
//   i_retire        : one instruction retires this cycle
//   o_cycle_cnt     : cycles counted since reset
//   o_instret_cnt   : instructions retired since reset
`ifdef PERF_CNT_EN
module perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_run,
  input  logic        i_retire,
  output logic [63:0] o_cycle_cnt,
  output logic [63:0] o_instret_cnt
);

  logic [63:0] r_cycle;
  logic [63:0] r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle   <= 64'd0;
      r_instret <= 64'd0;
    end else begin
      if (i_run)    r_cycle   <= r_cycle + 64'd1;
      if (i_retire) r_instret <= r_instret + 64'd1;
    end
  end

  assign o_cycle_cnt   = r_cycle;
  assign o_instret_cnt = r_instret;

endmodule
`endif

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle instruction sequencer for a simple RISC-V core.
// Walks IDLE -> FETCH -> IWAIT -> EXEC -> (MEM -> DWAIT ->) WB -> FETCH,
// stopping in HALT on ebreak or on a misaligned next PC (trap).
// Optional feature macro: PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   imem_req/gnt/rvalid/rdata       : instruction fetch channel
//   pc, ir                          : fetch address / latched instruction
//   dec_memread/memwrite/regwrite/halt : decoder controls for ir
//   pc_next                         : next PC from the branch/jump datapath
//   dmem_req/we/gnt/rvalid          : data access channel
//   rf_we                           : register-file write strobe
//   dbg_state                       : current sequencer state (debug)
//   halted, trap                    : core stopped / stopped on misaligned PC
//   cycle_cnt, instret_cnt          : performance counters (PERF_CNT_EN only)
//
// Memory handshake (both channels): req is held high until the cycle gnt is
// seen with it; the response is a single-cycle rvalid in a later cycle, and is
// only consumed while waiting for it (IWAIT/DWAIT). An rvalid seen in any
// other state, including one left over from before a reset, is dropped.
module cpu_seq
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  input  logic        dec_memread,
  input  logic        dec_memwrite,
  input  logic        dec_regwrite,
  input  logic        dec_halt,
  input  logic [31:0] pc_next,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  output logic        rf_we,
  output state_t      dbg_state,
  output logic        halted,
  output logic        trap
`ifdef PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_trap;
  logic        w_ir_load;
  logic        w_pc_load;
  logic        w_trap_set;
  logic        w_misaligned;

  assign w_misaligned = |pc_next[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and datapath load enables
  always_comb begin
    w_next     = r_state;
    w_ir_load  = 1'b0;
    w_pc_load  = 1'b0;
    w_trap_set = 1'b0;
    case (r_state)
      S_IDLE:  w_next = S_FETCH;
      S_FETCH: if (imem_gnt) w_next = S_IWAIT;
      S_IWAIT: begin
        if (imem_rvalid) begin
          w_next    = S_EXEC;
          w_ir_load = 1'b1;
        end
      end
      S_EXEC: begin
        if (dec_halt)                         w_next = S_HALT;
        else if (dec_memread || dec_memwrite) w_next = S_MEM;
        else                                  w_next = S_WB;
      end
      S_MEM:   if (dmem_gnt) w_next = S_DWAIT;
      S_DWAIT: if (dmem_rvalid) w_next = S_WB;
      S_WB: begin
        // The register write still happens on a trap; only the PC update
        // is suppressed so pc points at the offending instruction.
        if (w_misaligned) begin
          w_next     = S_HALT;
          w_trap_set = 1'b1;
        end else begin
          w_next    = S_FETCH;
          w_pc_load = 1'b1;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // PC, instruction register and trap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_ir   <= NOP_INSTR;
      r_trap <= 1'b0;
    end else begin
      if (w_ir_load)  r_ir   <= imem_rdata;
      if (w_pc_load)  r_pc   <= pc_next;
      if (w_trap_set) r_trap <= 1'b1;
    end
  end

  // Strobes decode the registered state only, so they are glitch-free and
  // mutually exclusive by construction.
  assign imem_req  = (r_state == S_FETCH);
  assign dmem_req  = (r_state == S_MEM);
  assign dmem_we   = dmem_req & dec_memwrite;
  assign rf_we     = (r_state == S_WB) & dec_regwrite;
  assign halted    = (r_state == S_HALT);
  assign trap      = r_trap;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign dbg_state = r_state;

`ifdef PERF_CNT_EN
  logic w_run;
  logic w_retire;

  assign w_run    = (r_state != S_HALT);
  assign w_retire = (r_state == S_WB);

  perf_cnt u_perf_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_run         (w_run),
    .i_retire      (w_retire),
    .o_cycle_cnt   (cycle_cnt),
    .o_instret_cnt (instret_cnt)
  );
`endif

endmodule

// File: tb/tb_cpu_seq.sv
module tb_cpu_seq;
  import cpu_pkg::*;

  localparam int          W      = 70;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        imem_req;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        dec_memread = 1'b0;
  logic        dec_memwrite = 1'b0;
  logic        dec_regwrite = 1'b0;
  logic        dec_halt = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic        rf_we;
  state_t      dbg_state;
  logic        halted;
  logic        trap;
`ifdef PERF_CNT_EN
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
`endif

  cpu_seq #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .ir           (ir),
    .dec_memread  (dec_memread),
    .dec_memwrite (dec_memwrite),
    .dec_regwrite (dec_regwrite),
    .dec_halt     (dec_halt),
    .pc_next      (pc_next),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .rf_we        (rf_we),
    .dbg_state    (dbg_state),
    .halted       (halted),
    .trap         (trap)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  // ---------------- instruction descriptors ----------------
  typedef struct {
    logic [31:0] rdata;
    int          gnt_wait;   // FETCH cycles without grant
    int          rv_wait;    // cycles from grant to rvalid (>=1)
    int          dgnt_wait;
    int          drv_wait;
    logic        memread;
    logic        memwrite;
    logic        regwrite;
    logic        halt;
    logic [31:0] pc_next;
  } ins_t;

  function automatic ins_t mk(input logic [31:0] rdata, input int gw, input int rw,
                              input int dgw, input int drw, input logic rd,
                              input logic wr, input logic rgw, input logic hlt,
                              input logic [31:0] pcn);
    ins_t d;
    d.rdata = rdata; d.gnt_wait = gw; d.rv_wait = rw; d.dgnt_wait = dgw;
    d.drv_wait = drw; d.memread = rd; d.memwrite = wr; d.regwrite = rgw;
    d.halt = hlt; d.pc_next = pcn;
    return d;
  endfunction

  ins_t ins_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- memory / decoder driver ----------------
  ins_t cur;
  int   i_wait = 0, i_cnt = 0, d_wait = 0, d_cnt = 0;
  bit   i_pend = 1'b0, d_pend = 1'b0;

  always @(negedge clk) begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    if (i_pend) begin
      i_cnt--;
      if (i_cnt <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = cur.rdata;
        i_pend      = 1'b0;
      end
    end else if (imem_req && ins_q.size() > 0) begin
      if (i_wait < ins_q[0].gnt_wait) i_wait++;
      else begin
        imem_gnt     = 1'b1;
        cur          = ins_q.pop_front();
        i_wait       = 0;
        i_pend       = 1'b1;
        i_cnt        = cur.rv_wait;
        dec_memread  = cur.memread;
        dec_memwrite = cur.memwrite;
        dec_regwrite = cur.regwrite;
        dec_halt     = cur.halt;
        pc_next      = cur.pc_next;
      end
    end
    if (d_pend) begin
      d_cnt--;
      if (d_cnt <= 0) begin
        dmem_rvalid = 1'b1;
        d_pend      = 1'b0;
      end
    end else if (dmem_req) begin
      if (d_wait < cur.dgnt_wait) d_wait++;
      else begin
        dmem_gnt = 1'b1;
        d_wait   = 0;
        d_pend   = 1'b1;
        d_cnt    = cur.drv_wait;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  // Expected per-cycle outputs {imem_req,dmem_req,dmem_we,rf_we,halted,trap,pc,ir}
  logic [W-1:0] exp_q[$];
  logic [31:0]  m_pc;
  logic [31:0]  m_ir;
  bit           m_halted;

  function automatic void push(input logic ireq, input logic dreq, input logic dwe,
                               input logic rfw, input logic hlt, input logic trp,
                               input logic [31:0] p, input logic [31:0] i);
    exp_q.push_back({ireq, dreq, dwe, rfw, hlt, trp, p, i});
  endfunction

  function automatic void model_instr(input ins_t d);
    for (int k = 0; k <= d.gnt_wait; k++) push(1, 0, 0, 0, 0, 0, m_pc, m_ir);
    for (int k = 0; k < d.rv_wait; k++)   push(0, 0, 0, 0, 0, 0, m_pc, m_ir);
    m_ir = d.rdata;
    push(0, 0, 0, 0, 0, 0, m_pc, m_ir);                       // decode cycle
    if (d.halt) begin
      for (int k = 0; k < 3; k++) push(0, 0, 0, 0, 1, 0, m_pc, m_ir);
      m_halted = 1'b1;
      return;
    end
    if (d.memread || d.memwrite) begin
      for (int k = 0; k <= d.dgnt_wait; k++) push(0, 1, d.memwrite, 0, 0, 0, m_pc, m_ir);
      for (int k = 0; k < d.drv_wait; k++)   push(0, 0, 0, 0, 0, 0, m_pc, m_ir);
    end
    push(0, 0, 0, d.regwrite, 0, 0, m_pc, m_ir);               // write-back
    if (d.pc_next[1:0] != 2'b00) begin
      for (int k = 0; k < 3; k++) push(0, 0, 0, 0, 1, 1, m_pc, m_ir);
      m_halted = 1'b1;
    end else begin
      m_pc = d.pc_next;
    end
  endfunction

  // ---------------- scoreboard / monitor ----------------
  bit           checking = 1'b0;
  int           cyc = 0, rf_cyc = -1, iwait_cyc = -1, halt_cyc = -1, fetch_reqs = 0;
  state_t       st0 = S_HALT, st1 = S_HALT;
  logic [W-1:0] exp_v, got_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; rf_cyc = -1; iwait_cyc = -1; halt_cyc = -1; fetch_reqs = 0;
      st0 = S_HALT; st1 = S_HALT;
    end else begin
      if (cyc == 0) st0 = dbg_state;
      if (cyc == 1) st1 = dbg_state;
      if (rf_we && rf_cyc < 0) rf_cyc = cyc;
      if (dbg_state == S_IWAIT && iwait_cyc < 0) iwait_cyc = cyc;
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      if (imem_req && iwait_cyc < 0) fetch_reqs++;
      if (checking && exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {imem_req, dmem_req, dmem_we, rf_we, halted, trap, pc, ir};
        checks++;
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL stream cyc=%0d got{ireq,dreq,we,rfwe,hlt,trap,pc,ir}=%0h expected=%0h",
                   cyc, got_v, exp_v);
        end
      end
      cyc++;
    end
  end

  // ---------------- test helpers ----------------
  task automatic begin_prog();
    @(posedge clk);
    #2 rst_n = 1'b0;
    checking = 1'b0;
    #1;
    chk("rst_pc", 64'(pc), 64'(RST_PC));
    chk("rst_ir", 64'(ir), 64'(NOP));
    chk("rst_ctl", 64'({imem_req, dmem_req, rf_we, halted, trap}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    exp_q.delete();
    m_pc = RST_PC; m_ir = NOP; m_halted = 1'b0;
    push(0, 0, 0, 0, 0, 0, m_pc, m_ir);                        // IDLE cycle
  endtask

  task automatic add(input ins_t d);
    ins_q.push_back(d);
    model_instr(d);
  endtask

  task automatic run_prog(input int keep);
    if (keep > 0) begin
      while (exp_q.size() > keep) void'(exp_q.pop_back());
    end else if (!m_halted) begin
      push(1, 0, 0, 0, 0, 0, m_pc, m_ir);                      // next fetch, never granted
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    checking = 1'b1;
    for (int n = 0; n < 300 && exp_q.size() > 0; n++) @(posedge clk);
    chk("timeout_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    checking = 1'b0;
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (2) @(posedge clk);

    // T1: addi, immediate grant, rvalid next cycle; then a jump-like instr
    begin_prog();
    add(mk(32'h0050_0093, 0, 1, 0, 0, 0, 0, 1, 0, 32'h8000_0004));
    add(mk(32'h0400_0063, 0, 2, 0, 0, 0, 0, 0, 0, 32'h8000_0040));
    run_prog(0);
    chk("t1_state_idle", 64'(st0), 64'(S_IDLE));
    chk("t1_state_fetch", 64'(st1), 64'(S_FETCH));
    chk("t1_rf_we_cycle", 64'(rf_cyc), 64'd4);
    chk("t1_iwait_cycle", 64'(iwait_cyc), 64'd2);
    chk("t1_pc", 64'(pc), 64'h8000_0040);
    chk("t1_ir", 64'(ir), 64'h0400_0063);
`ifdef PERF_CNT_EN
    chk("t1_instret", instret_cnt, 64'd2);
`endif

    // T2: grant withheld 3 cycles
    begin_prog();
    add(mk(32'h0000_0013, 3, 1, 0, 0, 0, 0, 0, 0, 32'h8000_0004));
    run_prog(0);
    chk("t2_fetch_req_cycles", 64'(fetch_reqs), 64'd4);
    chk("t2_iwait_cycle", 64'(iwait_cyc), 64'd5);
    chk("t2_no_rf_we", 64'(rf_cyc), -64'sd1);
    chk("t2_pc", 64'(pc), 64'h8000_0004);

    // T3: load with rvalid 2 cycles late, then store with grant 1 cycle late
    begin_prog();
    add(mk(32'h0000_a103, 0, 1, 0, 3, 1, 0, 1, 0, 32'h8000_0004));
    add(mk(32'h0020_a223, 0, 1, 1, 1, 0, 1, 0, 0, 32'h8000_0008));
    run_prog(0);
    chk("t3_load_rf_we_cycle", 64'(rf_cyc), 64'd8);
    chk("t3_pc", 64'(pc), 64'h8000_0008);

    // T4: ebreak
    begin_prog();
    add(mk(32'h0010_0073, 0, 1, 0, 0, 0, 0, 0, 1, 32'h8000_0004));
    run_prog(0);
    chk("t4_halt_cycle", 64'(halt_cyc), 64'd4);
    chk("t4_pc", 64'(pc), 64'h8000_0000);
    chk("t4_halted_noreq", 64'({halted, imem_req, trap}), 64'b100);
`ifdef PERF_CNT_EN
    chk("t4_cycles", cycle_cnt, 64'd4);
`endif

    // T5: misaligned next PC -> trap
    begin_prog();
    add(mk(32'h0060_00ef, 0, 1, 0, 0, 0, 0, 1, 0, 32'h8000_0006));
    run_prog(0);
    chk("t5_rf_we_cycle", 64'(rf_cyc), 64'd4);
    chk("t5_halt_cycle", 64'(halt_cyc), 64'd5);
    chk("t5_trap_halted", 64'({trap, halted}), 64'b11);
    chk("t5_pc", 64'(pc), 64'h8000_0000);

    // T6: reset while waiting for load data; stale dmem_rvalid afterwards
    begin_prog();
    add(mk(32'h0000_a103, 0, 1, 0, 6, 1, 0, 1, 0, 32'h8000_0004));
    run_prog(7);                                               // up to 2nd DWAIT cycle
    chk("t6_in_dwait", 64'(dbg_state), 64'(S_DWAIT));
    begin_prog();                                              // async reset mid-transaction
    add(mk(32'h0050_0093, 0, 1, 0, 0, 0, 0, 1, 0, 32'h8000_0004));
    run_prog(0);
    chk("t6_state_idle", 64'(st0), 64'(S_IDLE));
    chk("t6_state_fetch", 64'(st1), 64'(S_FETCH));
    chk("t6_rf_we_cycle", 64'(rf_cyc), 64'd4);
    chk("t6_pc", 64'(pc), 64'h8000_0004);
    chk("t6_stale_consumed", 64'(d_pend), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
